pic_inta_sequencer: RTL and testbench

CPU-side interrupt-acknowledge sequencer sitting directly downstream of the 8259-style interrupt controller. It synchronises the controller's INT output and generates the two-pulse INTA acknowledge cycle. It captures the 8-bit vector the controller drives on DATABUS during the second pulse and hands the vector to the core over a valid/ready handshake. When the core signals end of service, it writes a non-specific EOI (OCW2) back to the controller.

---
 rtl/pic_inta_sequencer.sv | 138 +++++++++++++
 tb/tb_pic_inta_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259-style controller: synchronises INT,
// runs the two-pulse INTA cycle, presents the captured vector and writes back a non-specific EOI.
module pic_inta_sequencer #(
  parameter int          INTA_LOW_CYCLES = 2,
  parameter int          INTA_GAP_CYCLES = 2,
  parameter logic [7:0]  EOI_CMD         = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       int_in,
  output logic       inta_n,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic [7:0] vec_data,
  input  logic       eoi_req,
  output logic       busy
);

  // state       | meaning
  // IDLE        | waiting for synchronised INT while enabled
  // ACK1        | first INTA pulse low
  // GAP         | INTA high between pulses
  // ACK2        | second INTA pulse low, vector captured on last cycle
  // PRESENT     | vector offered to the core
  // WAIT_EOI    | ISR running, waiting for end of service
  // EOI_SETUP   | chip select and EOI byte set up ahead of WR
  // EOI_WR      | WR strobe low
  // EOI_HOLD    | WR released, bus still driven
  typedef enum logic [3:0] {
    S_IDLE, S_ACK1, S_GAP, S_ACK2, S_PRESENT,
    S_WAIT_EOI, S_EOI_SETUP, S_EOI_WR, S_EOI_HOLD
  } state_t;

  localparam logic [3:0] LOW_LD = 4'(INTA_LOW_CYCLES - 1);
  localparam logic [3:0] GAP_LD = 4'(INTA_GAP_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       sync1, int_s;
  logic       eoi_pend;
  logic       eoi_hit;

  logic       inta_n_nxt, cs_n_nxt, wr_n_nxt, data_oe_nxt, vec_valid_nxt, busy_nxt;
  logic [7:0] data_out_nxt;

  assign eoi_hit = eoi_pend | eoi_req;
  assign rd_n    = 1'b1;
  assign a0      = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      int_s     <= 1'b0;
      state     <= S_IDLE;
      cnt       <= 4'd0;
      eoi_pend  <= 1'b0;
      inta_n    <= 1'b1;
      cs_n      <= 1'b1;
      wr_n      <= 1'b1;
      data_oe   <= 1'b0;
      data_out  <= 8'h00;
      vec_valid <= 1'b0;
      vec_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      sync1     <= int_in;
      int_s     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      inta_n    <= inta_n_nxt;
      cs_n      <= cs_n_nxt;
      wr_n      <= wr_n_nxt;
      data_oe   <= data_oe_nxt;
      data_out  <= data_out_nxt;
      vec_valid <= vec_valid_nxt;
      busy      <= busy_nxt;
      if (state == S_ACK2 && cnt == 4'd0)
        vec_data <= data_in;
      // EOI requests only count while a vector is being served
      if (state == S_EOI_HOLD)
        eoi_pend <= 1'b0;
      else if ((state == S_PRESENT || state == S_WAIT_EOI) && eoi_req)
        eoi_pend <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (enable && int_s) begin
        state_nxt = S_ACK1;
        cnt_nxt   = LOW_LD;
      end
      S_ACK1: if (cnt == 4'd0) begin
        state_nxt = S_GAP;
        cnt_nxt   = GAP_LD;
      end else cnt_nxt = cnt - 4'd1;
      S_GAP: if (cnt == 4'd0) begin
        state_nxt = S_ACK2;
        cnt_nxt   = LOW_LD;
      end else cnt_nxt = cnt - 4'd1;
      S_ACK2: if (cnt == 4'd0) state_nxt = S_PRESENT;
              else cnt_nxt = cnt - 4'd1;
      S_PRESENT: if (vec_ready) state_nxt = eoi_hit ? S_EOI_SETUP : S_WAIT_EOI;
      S_WAIT_EOI: if (eoi_hit) state_nxt = S_EOI_SETUP;
      S_EOI_SETUP: begin
        state_nxt = S_EOI_WR;
        cnt_nxt   = LOW_LD;
      end
      S_EOI_WR: if (cnt == 4'd0) state_nxt = S_EOI_HOLD;
                else cnt_nxt = cnt - 4'd1;
      S_EOI_HOLD: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that every pin is a flop
  always_comb begin
    inta_n_nxt    = !(state_nxt == S_ACK1 || state_nxt == S_ACK2);
    data_oe_nxt   = (state_nxt == S_EOI_SETUP || state_nxt == S_EOI_WR ||
                     state_nxt == S_EOI_HOLD);
    cs_n_nxt      = !data_oe_nxt;
    wr_n_nxt      = !(state_nxt == S_EOI_WR);
    data_out_nxt  = data_oe_nxt ? EOI_CMD : 8'h00;
    vec_valid_nxt = (state_nxt == S_PRESENT);
    busy_nxt      = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer with a small 8259 model on the data bus.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, enable, int_in, vec_ready, eoi_req;
  logic       inta_n, cs_n, wr_n, rd_n, a0, data_oe, vec_valid, busy;
  logic [7:0] data_out, data_in, vec_data;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         ack_num = 0;
  logic [7:0] vecs [2];

  always #5 clk = ~clk;

  pic_inta_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .int_in(int_in),
    .inta_n(inta_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .eoi_req(eoi_req), .busy(busy)
  );

  // Controller model: drives the vector only during every second INTA pulse
  always @(negedge inta_n) ack_num = ack_num + 1;

  always_comb begin
    data_in = 8'hFF;
    if (!inta_n && ack_num != 0 && (ack_num % 2) == 0)
      data_in = vecs[((ack_num / 2) - 1) % 2];
  end

  task automatic test_reset();
    logic ok;
    rst_n = 1'b0; enable = 1'b1; int_in = 1'b0; vec_ready = 1'b0; eoi_req = 1'b0;
    ack_num = 0;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if ({inta_n, cs_n, wr_n, rd_n, a0, data_oe, vec_valid, busy} !== 8'b11110000 ||
        data_out !== 8'h00 || vec_data !== 8'h00)
      $display("FAIL reset_outputs got ctl=%b dout=%h vec=%h exp ctl=11110000 dout=00 vec=00",
               {inta_n, cs_n, wr_n, rd_n, a0, data_oe, vec_valid, busy}, data_out, vec_data);
    else pass_cnt++;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inta_n !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    total_cnt++;
    if (!ok) $display("FAIL idle_quiet got inta_n=%b busy=%b exp 1 0", inta_n, busy);
    else pass_cnt++;
  endtask

  task automatic test_ack();
    logic exp_inta [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic ok;
    vecs[0] = 8'hB9; vecs[1] = 8'hB9; ack_num = 0;
    int_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total_cnt++;
      if (inta_n !== exp_inta[i])
        $display("FAIL inta_pattern edge %0d got %b exp %b", i, inta_n, exp_inta[i]);
      else pass_cnt++;
      if (i == 3) int_in = 1'b0;
    end
    total_cnt++;
    if (vec_valid !== 1'b1 || vec_data !== 8'hB9)
      $display("FAIL vec_present got valid=%b data=%h exp 1 b9", vec_valid, vec_data);
    else pass_cnt++;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vec_valid !== 1'b1 || vec_data !== 8'hB9 || inta_n !== 1'b1) ok = 1'b0;
    end
    total_cnt++;
    if (!ok) $display("FAIL vec_hold got valid=%b data=%h exp 1 b9", vec_valid, vec_data);
    else pass_cnt++;
    vec_ready = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0;
    total_cnt++;
    if (vec_valid !== 1'b0 || busy !== 1'b1 || cs_n !== 1'b1)
      $display("FAIL handshake got valid=%b busy=%b cs_n=%b exp 0 1 1", vec_valid, busy, cs_n);
    else pass_cnt++;
  endtask

  task automatic test_eoi();
    logic exp_cs [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_wr [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_oe [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || cs_n !== 1'b1)
      $display("FAIL wait_eoi got busy=%b cs_n=%b exp 1 1", busy, cs_n);
    else pass_cnt++;
    eoi_req = 1'b1;
    @(negedge clk);
    eoi_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_d = exp_oe[i] ? 8'h20 : 8'h00;
      total_cnt++;
      if (cs_n !== exp_cs[i] || wr_n !== exp_wr[i] || data_oe !== exp_oe[i] ||
          a0 !== 1'b0 || data_out !== exp_d || busy !== !exp_cs[i])
        $display("FAIL eoi_write cycle %0d got cs=%b wr=%b oe=%b a0=%b d=%h busy=%b exp cs=%b wr=%b oe=%b a0=0 d=%h",
                 i, cs_n, wr_n, data_oe, a0, data_out, busy, exp_cs[i], exp_wr[i], exp_oe[i], exp_d);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_early_eoi();
    logic ok;
    vecs[0] = 8'h4C; vecs[1] = 8'h4C; ack_num = 0;
    int_in = 1'b1;
    for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
    int_in = 1'b0;
    for (int i = 0; i < 40 && vec_valid !== 1'b1; i++) @(negedge clk);
    total_cnt++;
    if (vec_valid !== 1'b1 || vec_data !== 8'h4C)
      $display("FAIL early_vec got valid=%b data=%h exp 1 4c", vec_valid, vec_data);
    else pass_cnt++;
    vec_ready = 1'b1; eoi_req = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0; eoi_req = 1'b0;
    total_cnt++;
    if (cs_n !== 1'b0 || wr_n !== 1'b1 || vec_valid !== 1'b0 || data_out !== 8'h20)
      $display("FAIL early_eoi_setup got cs=%b wr=%b valid=%b d=%h exp 0 1 0 20",
               cs_n, wr_n, vec_valid, data_out);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || cs_n !== 1'b1 || data_oe !== 1'b0)
      $display("FAIL early_eoi_done got busy=%b cs=%b oe=%b exp 0 1 0", busy, cs_n, data_oe);
    else pass_cnt++;
    eoi_req = 1'b1;
    @(negedge clk);
    eoi_req = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cs_n !== 1'b1 || wr_n !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    total_cnt++;
    if (!ok) $display("FAIL idle_eoi_ignored got cs=%b wr=%b busy=%b exp 1 1 0", cs_n, wr_n, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic ok;
    vecs[0] = 8'hB9; vecs[1] = 8'hBB; ack_num = 0;
    int_in = 1'b1;
    for (int i = 0; i < 40 && vec_valid !== 1'b1; i++) @(negedge clk);
    total_cnt++;
    if (vec_valid !== 1'b1 || vec_data !== 8'hB9)
      $display("FAIL b2b_first got valid=%b data=%h exp 1 b9", vec_valid, vec_data);
    else pass_cnt++;
    vec_ready = 1'b1; eoi_req = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0; eoi_req = 1'b0;
    total_cnt++;
    if (cs_n !== 1'b0) $display("FAIL b2b_eoi1 got cs_n=%b exp 0", cs_n);
    else pass_cnt++;
    for (int i = 0; i < 40 && vec_valid !== 1'b1; i++) @(negedge clk);
    int_in = 1'b0;
    total_cnt++;
    if (vec_valid !== 1'b1 || vec_data !== 8'hBB || ack_num !== 4)
      $display("FAIL b2b_second got valid=%b data=%h pulses=%0d exp 1 bb 4", vec_valid, vec_data, ack_num);
    else pass_cnt++;
    vec_ready = 1'b1; eoi_req = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0; eoi_req = 1'b0;
    total_cnt++;
    if (cs_n !== 1'b0) $display("FAIL b2b_eoi2 got cs_n=%b exp 0", cs_n);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0 || inta_n !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    total_cnt++;
    if (!ok || ack_num !== 4)
      $display("FAIL b2b_stop got busy=%b pulses=%0d exp 0 4", busy, ack_num);
    else pass_cnt++;
  endtask

  task automatic test_disrupt();
    logic ok;
    vecs[0] = 8'h5A; vecs[1] = 8'h5A; ack_num = 0;
    int_in = 1'b1;
    for (int i = 0; i < 20 && ack_num !== 1; i++) @(negedge clk);
    for (int i = 0; i < 20 && inta_n !== 1'b1; i++) @(negedge clk);
    int_in = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 40 && vec_valid !== 1'b1; i++) @(negedge clk);
    total_cnt++;
    if (vec_valid !== 1'b1 || vec_data !== 8'h5A)
      $display("FAIL gap_drop got valid=%b data=%h exp 1 5a", vec_valid, vec_data);
    else pass_cnt++;
    vec_ready = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || cs_n !== 1'b1)
      $display("FAIL no_stale_eoi got busy=%b cs_n=%b exp 1 1", busy, cs_n);
    else pass_cnt++;
    eoi_req = 1'b1;
    @(negedge clk);
    eoi_req = 1'b0;
    repeat (5) @(negedge clk);
    int_in = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inta_n !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    total_cnt++;
    if (!ok) $display("FAIL disabled_idle got inta_n=%b busy=%b exp 1 0", inta_n, busy);
    else pass_cnt++;
    ack_num = 0;
    enable = 1'b1;
    for (int i = 0; i < 40 && !(ack_num == 2 && inta_n === 1'b0); i++) @(negedge clk);
    rst_n = 1'b0; int_in = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (inta_n !== 1'b1 || busy !== 1'b0 || vec_valid !== 1'b0 || cs_n !== 1'b1)
      $display("FAIL reset_in_ack2 got inta_n=%b busy=%b valid=%b cs_n=%b exp 1 0 0 1",
               inta_n, busy, vec_valid, cs_n);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ack();
    test_eoi();
    test_early_eoi();
    test_back_to_back();
    test_disrupt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
